// File: rtl/canbac_n_seq.sv
// canbac_n_seq: sequential single-precision n-th root, ketqua = exp(ln(y)/n).
// One float adder, one multiplier and one divider are shared by all states.
// The ln and exp series each produce one term per cycle.
// Arithmetic truncates (round toward zero) and flushes subnormals to zero.
// Optional build macro CANBAC_SPECIAL_EN: y=0, y=1.0 and n=1.0 finish in one
// cycle with exact results instead of taking the error or series path.
module canbac_n_seq #(
    parameter int unsigned LN_TERMS  = 29,
    parameter int unsigned EXP_TERMS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] y,
    input  logic [31:0] n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ketqua
);

    localparam logic [31:0] F_ONE     = 32'h3F80_0000;
    localparam logic [31:0] F_NEG_ONE = 32'hBF80_0000;
    localparam logic [31:0] F_QNAN    = 32'h7FC0_0000;
    localparam logic [5:0]  LN_LAST   = 6'(LN_TERMS);
    localparam logic [5:0]  EXP_LAST  = 6'(EXP_TERMS);

    typedef enum logic [2:0] {IDLE, RECIP, LN, SCALE, EXP, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] y_r, n_r, r_r, x_r, p_r, acc_r;
    logic [5:0]  k_r;
    logic        big_r;
    logic        in_err, spec_hit;
    logic [31:0] spec_val;
    logic [31:0] mul_a, mul_b, mul_o;
    logic [31:0] div_a, div_b, div_o, kf;
    logic [31:0] add_a, add_b, add_o;

    // Truncating float add; zero operands pass the other operand through.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       hi, lo, res;
        logic [26:0]       mh, ml;
        logic [27:0]       s;
        logic [7:0]        sh;
        logic [4:0]        msb;
        logic signed [9:0] e;
        if (a[30:0] >= b[30:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        sh  = hi[30:23] - lo[30:23];
        mh  = {1'b1, hi[22:0], 3'b000};
        ml  = {1'b1, lo[22:0], 3'b000};
        ml  = (sh > 8'd26) ? '0 : (ml >> sh);
        e   = $signed({2'b00, hi[30:23]});
        msb = '0;
        if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, ml};
        else                  s = {1'b0, mh} - {1'b0, ml};
        if (s[27]) begin
            s = s >> 1;
            e = e + 10'sd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++) if (s[i]) msb = 5'(i);
            s = s << (5'd26 - msb);
            e = e - $signed({5'd0, 5'd26 - msb});
        end
        if (a[30:23] == 8'd0)      res = b;
        else if (b[30:23] == 8'd0) res = a;
        else if (s == '0)          res = '0;
        else if (e >= 10'sd255)    res = {hi[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0)      res = '0;
        else                       res = {hi[31], e[7:0], s[25:3]};
        return res;
    endfunction

    // Truncating float multiply.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [24:0]       ph;
        logic [22:0]       f;
        logic signed [9:0] e;
        logic              sg;
        logic [31:0]       res;
        sg = a[31] ^ b[31];
        ph = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
        e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (ph[24]) begin
            f = ph[23:1];
            e = e + 10'sd1;
        end else begin
            f = ph[22:0];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) res = {sg, 31'd0};
        else if (e >= 10'sd255)                   res = {sg, 8'hFF, 23'd0};
        else if (e <= 10'sd0)                     res = {sg, 31'd0};
        else                                      res = {sg, e[7:0], f};
        return res;
    endfunction

    // Truncating float divide; a zero divisor yields a signed infinity.
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [24:0]       q;
        logic [22:0]       f;
        logic signed [9:0] e;
        logic              sg;
        logic [31:0]       res;
        sg = a[31] ^ b[31];
        q  = 25'({1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]});
        e  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd126;
        if (q[24]) begin
            f = q[23:1];
            e = e + 10'sd1;
        end else begin
            f = q[22:0];
        end
        if (a[30:23] == 8'd0)      res = {sg, 31'd0};
        else if (b[30:23] == 8'd0) res = {sg, 8'hFF, 23'd0};
        else if (e >= 10'sd255)    res = {sg, 8'hFF, 23'd0};
        else if (e <= 10'sd0)      res = {sg, 31'd0};
        else                       res = {sg, e[7:0], f};
        return res;
    endfunction

    // Exact conversion of a term index 1..63 to float.
    function automatic logic [31:0] u6_to_f(input logic [5:0] k);
        logic [4:0] p;
        p = '0;
        for (int unsigned i = 0; i < 6; i++) if (k[i]) p = 5'(i);
        return {1'b0, 8'(8'd127 + {3'd0, p}), 23'({17'd0, k} << (5'd23 - p))};
    endfunction

    // Operand screening at start: illegal operands and optional fast cases.
    always_comb begin
        in_err = y[31] || (y[30:23] == 8'd0) || (n[30:23] == 8'd0) || (n[30:23] == 8'hFF);
        spec_hit = 1'b0;
        spec_val = '0;
`ifdef CANBAC_SPECIAL_EN
        if (y == '0) begin
            spec_hit = 1'b1;
            spec_val = '0;
        end else if (y == F_ONE) begin
            spec_hit = 1'b1;
            spec_val = F_ONE;
        end else if (n == F_ONE) begin
            spec_hit = 1'b1;
            spec_val = y;
        end
`else
        spec_hit = 1'b0;
        spec_val = '0;
`endif
    end

    // Multiplier: running power/term in LN and EXP, ln(y)*r in SCALE.
    always_comb begin
        mul_a = p_r;
        mul_b = x_r;
        if (state == SCALE) begin
            mul_a = big_r ? acc_r : {~acc_r[31], acc_r[30:0]};
            mul_b = r_r;
        end
        mul_o = fmul(mul_a, mul_b);
    end

    // Divider: 1/n in RECIP; first ln term is the series base itself, later terms divide by k.
    always_comb begin
        kf    = u6_to_f(k_r);
        div_a = mul_o;
        div_b = kf;
        if (state == RECIP) begin
            div_a = F_ONE;
            div_b = n_r;
        end else if (state == LN && k_r == 6'd1) begin
            div_a = x_r;
            div_b = big_r ? y_r : F_ONE;
        end
        div_o = fdiv(div_a, div_b);
    end

    // Adder: forms y-1 or 1-y in RECIP, otherwise accumulates the current term.
    always_comb begin
        add_a = acc_r;
        add_b = div_o;
        if (state == RECIP) begin
            add_a = big_r ? y_r : F_ONE;
            add_b = big_r ? F_NEG_ONE : {~y_r[31], y_r[30:0]};
        end
        add_o = fadd(add_a, add_b);
    end

    // Next-state and status decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (spec_hit || in_err) ? DONE : RECIP;
            RECIP:   state_nx = LN;
            LN:      if (k_r == LN_LAST) state_nx = SCALE;
            SCALE:   state_nx = EXP;
            EXP:     if (k_r == EXP_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    // State, operand capture, series registers and result load.
    // Result registers load on the edge into DONE so they are valid while done is high;
    // the exp accumulator starts at 1.0, so the k=0 term is already in the sum at the last term.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y_r    <= '0;
            n_r    <= '0;
            r_r    <= '0;
            x_r    <= '0;
            p_r    <= '0;
            acc_r  <= '0;
            k_r    <= '0;
            big_r  <= 1'b0;
            ketqua <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        y_r   <= y;
                        n_r   <= n;
                        big_r <= (y[30:23] > 8'd127);
                        acc_r <= '0;
                        k_r   <= 6'd1;
                        if (spec_hit || in_err) begin
                            ketqua <= spec_hit ? spec_val : F_QNAN;
                            err    <= ~spec_hit;
                        end
                    end
                end
                RECIP: begin
                    r_r <= div_o;
                    x_r <= add_o;
                    p_r <= '0;
                end
                LN: begin
                    acc_r <= add_o;
                    if (k_r == 6'd1) begin
                        x_r <= div_o;
                        p_r <= div_o;
                    end else begin
                        p_r <= mul_o;
                    end
                    k_r <= (k_r == LN_LAST) ? 6'd1 : k_r + 6'd1;
                end
                SCALE: begin
                    x_r   <= mul_o;
                    p_r   <= F_ONE;
                    acc_r <= F_ONE;
                    k_r   <= 6'd1;
                end
                EXP: begin
                    p_r   <= div_o;
                    acc_r <= add_o;
                    k_r   <= k_r + 6'd1;
                    if (k_r == EXP_LAST) begin
                        ketqua <= add_o;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
